mdu_unit: RTL and testbench
===========================

Name: mdu_unit

Overview:
- Parametrised multiply/divide unit, the multi-cycle companion to the single-cycle combinational ALU in the pipelined CPU core.
- Owns the HI/LO architectural registers.
- Executes signed and unsigned multiply and divide with a fixed, parametrised latency, and exposes a busy flag so the decode stage can stall dependent HI/LO instructions.
- MTHI/MTLO write HI/LO in one cycle; MFHI/MFLO read through a combinational read port.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- MUL_CYCLES, 5, busy cycles for MULT/MULTU (minimum 1).
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (minimum 1).
- CNT_W, 4, down-counter width; must hold max(MUL_CYCLES, DIV_CYCLES).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle request qualifying op/a/b.
- op  in  4  operation code (see package).
- a  in  WIDTH  operand A (rs).
- b  in  WIDTH  operand B (rt).
- busy  out  1  high while a multiply or divide is in flight.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.
- rdata  out  WIDTH  hi when op==MFHI, else lo; combinational.

Behaviour:
- Reset: hi=0, lo=0, busy=0, counter=0, pending result registers=0. Reset applies immediately (async) and aborts any in-flight op; the result is discarded.
- Opcodes:
  - MULT=0, MULTU=1, DIV=2, DIVU=3, MTHI=4, MTLO=5, MFHI=6, MFLO=7.
  - 8-15 are reserved: ignored, no state change.
- Acceptance: start is accepted only when busy==0. start while busy==1 is ignored entirely, including MTHI/MTLO.
- MTHI/MTLO: on an accepted start, hi<=a (or lo<=a) at that edge; busy stays 0.
- MULT/MULTU, DIV/DIVU start at edge T:
  - Operands are latched and the result is computed into pending registers.
  - The counter is loaded with N-1 (N = MUL_CYCLES or DIV_CYCLES) and busy<=1.
  - busy is high for exactly N cycles (T+1..T+N).
  - hi/lo update at the edge ending cycle T+N, on the same edge busy falls.
  - A new start is accepted on that same edge.
- Multiply: the 2*WIDTH-bit product splits as hi=upper WIDTH bits, lo=lower WIDTH bits.
  - MULT uses signed operands; MULTU uses zero-extended operands.
- Divide: lo=quotient, hi=remainder.
  - DIV truncates toward zero; the remainder takes the sign of the dividend.
  - DIVU is unsigned.
- Divide by zero (b==0), full latency still applies:
  - DIV/DIVU: lo=all ones, hi=a.
- Signed overflow, DIV with a=most negative, b=-1: lo=a, hi=0.
- MFHI/MFLO do not change state; rdata is valid at any time, including while busy. Values read while busy are stale, and the stall is the decoder's job.

Optional Feature:
- Macro: MDU_MADD_EN.
- Defined: opcodes 8=MADD, 9=MADDU, 10=MSUB, 11=MSUBU are enabled.
  - {hi,lo} <= {hi,lo} +/- the product (signed or unsigned as for MULT/MULTU), with MUL_CYCLES latency.
  - Accumulation wraps modulo 2^(2*WIDTH).
  - The {hi,lo} value used is the one at commit time.
- Undefined: opcodes 8-11 stay reserved and are ignored; no accumulate logic is synthesised.

Decomposition:
- Package mdu_pkg holds:
  - the opcode localparams (MULT..MFLO, MADD..MSUBU);
  - default latency constants MUL_CYCLES_DEF=5 and DIV_CYCLES_DEF=10.
- One natural sub-module, mdu_latency_ctr: a loadable down-counter producing busy and a done pulse, parametrised by CNT_W.
- Arithmetic stays in mdu_unit.

Test Plan:
1. Reset then MTHI a=0x12345678, next cycle MTLO a=0x9ABCDEF0 -> hi=0x12345678, lo=0x9ABCDEF0, busy never asserted; MFHI gives rdata=0x12345678.
2. MULT a=0xFFFFFFFF (-1), b=0x00000002 -> busy high exactly 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFE. MULTU on the same operands -> hi=0x00000001, lo=0xFFFFFFFE.
3. DIV a=-7 (0xFFFFFFF9), b=2 -> after 10 busy cycles, lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIVU a=7, b=0 -> lo=0xFFFFFFFF, hi=0x00000007.
4. DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
5. During a MULT, issue MTLO a=0x55 at busy cycle 2 -> ignored; lo holds the product after completion. A new start on the edge busy falls is accepted.
6. Assert rst_n=0 at busy cycle 3 of a DIV -> busy, hi and lo drop to 0 immediately; after release no commit occurs. With MDU_MADD_EN: hi=0, lo=0xFFFFFFFF, then MADDU a=1, b=1 -> hi=1, lo=0.

Source files
------------

// File: rtl/mdu_pkg.sv
// mdu_pkg: opcode encodings and default latencies shared by the multiply/divide unit.
package mdu_pkg;

  // Base opcodes
  localparam logic [3:0] MULT  = 4'd0;
  localparam logic [3:0] MULTU = 4'd1;
  localparam logic [3:0] DIV   = 4'd2;
  localparam logic [3:0] DIVU  = 4'd3;
  localparam logic [3:0] MTHI  = 4'd4;
  localparam logic [3:0] MTLO  = 4'd5;
  localparam logic [3:0] MFHI  = 4'd6;
  localparam logic [3:0] MFLO  = 4'd7;

  // Accumulate opcodes (only decoded when MDU_MADD_EN is defined)
  localparam logic [3:0] MADD  = 4'd8;
  localparam logic [3:0] MADDU = 4'd9;
  localparam logic [3:0] MSUB  = 4'd10;
  localparam logic [3:0] MSUBU = 4'd11;

  // Default busy latencies
  localparam int MUL_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF = 10;

endpackage

// File: rtl/mdu_latency_ctr.sv
// mdu_latency_ctr: loadable down-counter. busy rises on load and stays high
// for load_val+1 cycles; done marks the last busy cycle, so the owner commits
// on the same edge busy falls. A load on that edge restarts the count.
module mdu_latency_ctr #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             busy,
  output logic             done
);

  logic [CNT_W-1:0] cnt_r;

  assign done = busy & (cnt_r == {CNT_W{1'b0}});

  // Count down while busy; load takes priority so back-to-back ops chain cleanly
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {CNT_W{1'b0}};
      busy  <= 1'b0;
    end else if (load) begin
      cnt_r <= load_val;
      busy  <= 1'b1;
    end else if (busy) begin
      if (cnt_r == {CNT_W{1'b0}}) begin
        busy <= 1'b0;
      end else begin
        cnt_r <= cnt_r - CNT_W'(1);
      end
    end else begin
      cnt_r <= cnt_r;
      busy  <= 1'b0;
    end
  end

endmodule

// File: rtl/mdu_unit.sv
// mdu_unit: multi-cycle multiply/divide unit owning HI/LO.
// The result is computed when the op is accepted and held in pending
// registers; HI/LO are written when the latency counter expires.
// Optional: define MDU_MADD_EN to enable MADD/MADDU/MSUB/MSUBU (opcodes 8-11).
module mdu_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = MUL_CYCLES_DEF,
  parameter int DIV_CYCLES = DIV_CYCLES_DEF,
  parameter int CNT_W      = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] rdata
);

  localparam logic [CNT_W-1:0] MUL_LD = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LD = CNT_W'(DIV_CYCLES - 1);

  logic             done_s;
  logic             accept_s;
  logic             is_mul_s;
  logic             is_div_s;
  logic             mul_sgn_s;
  logic             is_acc_s;
  logic             is_sub_s;
  logic [2*WIDTH-1:0] ext_a_s;
  logic [2*WIDTH-1:0] ext_b_s;
  logic [2*WIDTH-1:0] prod_s;
  logic             neg_a_s;
  logic             neg_b_s;
  logic [WIDTH-1:0] mag_a_s;
  logic [WIDTH-1:0] mag_b_s;
  logic [WIDTH-1:0] quo_u_s;
  logic [WIDTH-1:0] rem_u_s;
  logic [WIDTH-1:0] quo_s;
  logic [WIDTH-1:0] rem_s;
  logic [WIDTH-1:0] pend_hi_r;
  logic [WIDTH-1:0] pend_lo_r;
  logic             pend_acc_r;
  logic             pend_sub_r;

  // The last busy cycle also accepts, so a dependent op can issue as busy falls
  assign accept_s = start & (~busy | done_s);
  assign rdata    = (op == MFHI) ? hi : lo;

  mdu_latency_ctr #(.CNT_W(CNT_W)) u_ctr (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (accept_s & (is_mul_s | is_div_s)),
    .load_val (is_div_s ? DIV_LD : MUL_LD),
    .busy     (busy),
    .done     (done_s)
  );

  // Decode the opcode into datapath controls; unknown codes select nothing
  always_comb begin
    is_mul_s  = 1'b0;
    is_div_s  = 1'b0;
    mul_sgn_s = 1'b0;
    is_acc_s  = 1'b0;
    is_sub_s  = 1'b0;
    case (op)
      MULT:  begin is_mul_s = 1'b1; mul_sgn_s = 1'b1; end
      MULTU: begin is_mul_s = 1'b1; end
      DIV:   begin is_div_s = 1'b1; end
      DIVU:  begin is_div_s = 1'b1; end
`ifdef MDU_MADD_EN
      MADD:  begin is_mul_s = 1'b1; mul_sgn_s = 1'b1; is_acc_s = 1'b1; end
      MADDU: begin is_mul_s = 1'b1; is_acc_s = 1'b1; end
      MSUB:  begin is_mul_s = 1'b1; mul_sgn_s = 1'b1; is_acc_s = 1'b1; is_sub_s = 1'b1; end
      MSUBU: begin is_mul_s = 1'b1; is_acc_s = 1'b1; is_sub_s = 1'b1; end
`endif
      default: begin
        is_mul_s = 1'b0;
      end
    endcase
  end

  // One 2W x 2W multiplier serves both signednesses: the low 2W bits of the
  // sign- or zero-extended product are the correct result either way
  assign ext_a_s = {{WIDTH{mul_sgn_s & a[WIDTH-1]}}, a};
  assign ext_b_s = {{WIDTH{mul_sgn_s & b[WIDTH-1]}}, b};
  assign prod_s  = ext_a_s * ext_b_s;

  // Sign-magnitude divide; MIN/-1 naturally yields quotient=a, remainder=0
  always_comb begin
    neg_a_s = (op == DIV) & a[WIDTH-1];
    neg_b_s = (op == DIV) & b[WIDTH-1];
    mag_a_s = neg_a_s ? -a : a;
    mag_b_s = neg_b_s ? -b : b;
    if (b == {WIDTH{1'b0}}) begin
      quo_u_s = {WIDTH{1'b1}};
      rem_u_s = a;
      quo_s   = {WIDTH{1'b1}};
      rem_s   = a;
    end else begin
      quo_u_s = mag_a_s / mag_b_s;
      rem_u_s = mag_a_s % mag_b_s;
      quo_s   = (neg_a_s ^ neg_b_s) ? -quo_u_s : quo_u_s;
      rem_s   = neg_a_s ? -rem_u_s : rem_u_s;
    end
  end

  // HI/LO and pending-result state; a move on the commit edge overrides the commit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi         <= {WIDTH{1'b0}};
      lo         <= {WIDTH{1'b0}};
      pend_hi_r  <= {WIDTH{1'b0}};
      pend_lo_r  <= {WIDTH{1'b0}};
      pend_acc_r <= 1'b0;
      pend_sub_r <= 1'b0;
    end else begin
      if (done_s) begin
`ifdef MDU_MADD_EN
        if (pend_acc_r) begin
          if (pend_sub_r) begin
            {hi, lo} <= {hi, lo} - {pend_hi_r, pend_lo_r};
          end else begin
            {hi, lo} <= {hi, lo} + {pend_hi_r, pend_lo_r};
          end
        end else begin
          {hi, lo} <= {pend_hi_r, pend_lo_r};
        end
`else
        {hi, lo} <= {pend_hi_r, pend_lo_r};
`endif
      end
      if (accept_s) begin
        if (is_mul_s) begin
          pend_hi_r  <= prod_s[2*WIDTH-1:WIDTH];
          pend_lo_r  <= prod_s[WIDTH-1:0];
          pend_acc_r <= is_acc_s;
          pend_sub_r <= is_sub_s;
        end else if (is_div_s) begin
          pend_hi_r  <= rem_s;
          pend_lo_r  <= quo_s;
          pend_acc_r <= 1'b0;
          pend_sub_r <= 1'b0;
        end else if (op == MTHI) begin
          hi <= a;
        end else if (op == MTLO) begin
          lo <= a;
        end else begin
          pend_hi_r <= pend_hi_r;
        end
      end
    end
  end

endmodule

// File: tb/tb_mdu_unit.sv
// tb_mdu_unit: directed-vector bench for mdu_unit with hand-computed results.
module tb_mdu_unit;
  import mdu_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [3:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] rdata;

  int n_cmp;
  int n_bad;
  int lat;

  mdu_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo),
    .rdata (rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Present one start for one edge, then return #1 after that edge
  task automatic issue(input logic [3:0] o, input logic [31:0] va, input logic [31:0] vb);
    start = 1'b1;
    op    = o;
    a     = va;
    b     = vb;
    @(posedge clk);
    #1;
    start = 1'b0;
    op    = MFLO;
  endtask

  // Count edges until busy drops, bounded
  task automatic wait_idle(output int n);
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    start = 1'b0;
    op    = MFLO;
    a     = 32'h0;
    b     = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_busy", {63'h0, busy}, 64'h0);
    check_val("rst_hi", {32'h0, hi}, 64'h0);
    check_val("rst_lo", {32'h0, lo}, 64'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: moves
    issue(MTHI, 32'h12345678, 32'h0);
    check_val("mthi_busy", {63'h0, busy}, 64'h0);
    issue(MTLO, 32'h9ABCDEF0, 32'h0);
    check_val("mtlo_busy", {63'h0, busy}, 64'h0);
    check_val("mt_hi", {32'h0, hi}, 64'h12345678);
    check_val("mt_lo", {32'h0, lo}, 64'h9ABCDEF0);
    op = MFHI;
    #1;
    check_val("mfhi_rdata", {32'h0, rdata}, 64'h12345678);
    op = MFLO;
    #1;
    check_val("mflo_rdata", {32'h0, rdata}, 64'h9ABCDEF0);

    // reserved opcode: no state change, no busy
    issue(4'd12, 32'hDEADBEEF, 32'h1);
    check_val("rsv_busy", {63'h0, busy}, 64'h0);
    check_val("rsv_hilo", {hi, lo}, 64'h12345678_9ABCDEF0);

    // 2: multiply
    issue(MULT, 32'hFFFFFFFF, 32'h00000002);
    check_val("mult_busy", {63'h0, busy}, 64'h1);
    wait_idle(lat);
    check_val("mult_lat", 64'(lat), 64'd5);
    check_val("mult_hilo", {hi, lo}, 64'hFFFFFFFF_FFFFFFFE);
    issue(MULTU, 32'hFFFFFFFF, 32'h00000002);
    wait_idle(lat);
    check_val("multu_lat", 64'(lat), 64'd5);
    check_val("multu_hilo", {hi, lo}, 64'h00000001_FFFFFFFE);

    // 3: divide
    issue(DIV, 32'hFFFFFFF9, 32'h00000002);
    wait_idle(lat);
    check_val("div_lat", 64'(lat), 64'd10);
    check_val("div_hilo", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);
    issue(DIVU, 32'h00000007, 32'h00000000);
    wait_idle(lat);
    check_val("divu0_lat", 64'(lat), 64'd10);
    check_val("divu0_hilo", {hi, lo}, 64'h00000007_FFFFFFFF);
    issue(DIV, 32'h00000007, 32'h00000000);
    wait_idle(lat);
    check_val("div0_hilo", {hi, lo}, 64'h00000007_FFFFFFFF);
    issue(DIVU, 32'hFFFFFFF9, 32'h00000002);
    wait_idle(lat);
    check_val("divu_hilo", {hi, lo}, 64'h00000001_7FFFFFFC);

    // 4: signed overflow
    issue(DIV, 32'h80000000, 32'hFFFFFFFF);
    wait_idle(lat);
    check_val("divovf_hilo", {hi, lo}, 64'h00000000_80000000);

    // 5: move while busy ignored
    issue(MULT, 32'h00000003, 32'h00000005);
    @(posedge clk);
    #1;
    issue(MTLO, 32'h00000055, 32'h0);
    check_val("busy_mtlo_ign", {32'h0, lo}, 64'h80000000);
    wait_idle(lat);
    check_val("busy_mult_lat", 64'(lat), 64'd3);
    check_val("busy_mult_hilo", {hi, lo}, 64'h00000000_0000000F);

    // start on the edge busy falls is accepted (MTHI overrides committed hi)
    issue(MULTU, 32'h00000002, 32'h00000003);
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    check_val("lastcyc_busy", {63'h0, busy}, 64'h1);
    issue(MTHI, 32'h000000AB, 32'h0);
    check_val("fall_busy", {63'h0, busy}, 64'h0);
    check_val("fall_hilo", {hi, lo}, 64'h000000AB_00000006);

    // 6: async reset mid-divide
    issue(DIV, 32'd100, 32'd7);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    #2;
    rst_n = 1'b0;
    #1;
    check_val("arst_busy", {63'h0, busy}, 64'h0);
    check_val("arst_hilo", {hi, lo}, 64'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (15) begin
      @(posedge clk);
      #1;
    end
    check_val("post_rst_busy", {63'h0, busy}, 64'h0);
    check_val("post_rst_hilo", {hi, lo}, 64'h0);

`ifdef MDU_MADD_EN
    issue(MTLO, 32'hFFFFFFFF, 32'h0);
    issue(MADDU, 32'h00000001, 32'h00000001);
    wait_idle(lat);
    check_val("maddu_lat", 64'(lat), 64'd5);
    check_val("maddu_hilo", {hi, lo}, 64'h00000001_00000000);
    issue(MSUB, 32'h00000001, 32'h00000001);
    wait_idle(lat);
    check_val("msub_hilo", {hi, lo}, 64'h00000000_FFFFFFFF);
    issue(MADD, 32'hFFFFFFFF, 32'h00000001);
    wait_idle(lat);
    check_val("madd_hilo", {hi, lo}, 64'h00000000_FFFFFFFE);
`else
    issue(MTLO, 32'hFFFFFFFF, 32'h0);
    issue(MADDU, 32'h00000001, 32'h00000001);
    check_val("madd_off_busy", {63'h0, busy}, 64'h0);
    repeat (6) begin
      @(posedge clk);
      #1;
    end
    check_val("madd_off_hilo", {hi, lo}, 64'h00000000_FFFFFFFF);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
